// File: rtl/instruction_fetch_if.sv
// Fetch-stage bus: control inputs, program-load port and the fetched-instruction outputs.
// fetch_count is present only when IFETCH_FETCH_COUNT_EN is defined.
interface instruction_fetch_if;
  logic        start;
  logic [4:0]  pc;
  logic        stall;
  logic        flush;
  logic        prog_we;
  logic [2:0]  prog_addr;
  logic [31:0] prog_data;
  logic        pc_advance;
  logic [31:0] instr;
  logic [4:0]  instr_pc;
  logic        instr_valid;
  logic [1:0]  state;
  logic        halted;
`ifdef IFETCH_FETCH_COUNT_EN
  logic [15:0] fetch_count;
`endif

  modport slave (
    input  start, pc, stall, flush, prog_we, prog_addr, prog_data,
    output pc_advance, instr, instr_pc, instr_valid, state, halted
`ifdef IFETCH_FETCH_COUNT_EN
    , output fetch_count
`endif
  );

  modport master (
    output start, pc, stall, flush, prog_we, prog_addr, prog_data,
    input  pc_advance, instr, instr_pc, instr_valid, state, halted
`ifdef IFETCH_FETCH_COUNT_EN
    , input fetch_count
`endif
  );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: 8x32 program memory, IDLE/RUN/HALT FSM, 1-cycle pc->instr latency.
// stall holds the output register, flush kills it; optional fetch counter under IFETCH_FETCH_COUNT_EN.
module instruction_fetch (
  input  logic               clk,
  input  logic               rst,
  instruction_fetch_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    HALT = 2'b10
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] mem [8];
  logic [31:0] rd_word;
  logic        is_halt;
  logic        fetch;
  logic [31:0] instr_q;
  logic [4:0]  instr_pc_q;
  logic        instr_valid_q;
  logic        unused_pc_bits;

  // Byte offset within a word carries no information for word fetches.
  assign unused_pc_bits = ^bus.pc[1:0];

  assign rd_word = mem[bus.pc[4:2]];
  assign is_halt = (rd_word == 32'hFFFF_FFFF);
  assign fetch   = (state_q == RUN) && !bus.stall && !bus.flush;

  // Memory is deliberately outside the reset domain so programs survive reset.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && bus.prog_we)
      mem[bus.prog_addr] <= bus.prog_data;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (fetch && is_halt) state_d = HALT;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      instr_q       <= 32'h0000_0000;
      instr_pc_q    <= 5'd0;
      instr_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      case (state_q)
        RUN: begin
          if (bus.flush) begin
            instr_q       <= 32'h0000_0000;
            instr_valid_q <= 1'b0;
          end else if (!bus.stall) begin
            instr_q       <= rd_word;
            instr_pc_q    <= bus.pc;
            instr_valid_q <= 1'b1;
          end
        end
        default: instr_valid_q <= 1'b0;
      endcase
    end
  end

`ifdef IFETCH_FETCH_COUNT_EN
  logic [15:0] fetch_count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      fetch_count_q <= 16'd0;
    else if (fetch && fetch_count_q != 16'hFFFF)
      fetch_count_q <= fetch_count_q + 16'd1;
  end

  assign bus.fetch_count = fetch_count_q;
`endif

  assign bus.pc_advance  = fetch && !is_halt;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.state       = state_q;
  assign bus.halted      = (state_q == HALT);
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch; fetch_count checks only when IFETCH_FETCH_COUNT_EN is defined.
module tb_instruction_fetch;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  instruction_fetch_if ifc ();

  instruction_fetch dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [15:0] exp);
`ifdef IFETCH_FETCH_COUNT_EN
    chk(tag, {16'd0, ifc.fetch_count}, {16'd0, exp});
`else
    if (exp === 16'hxxxx) $display("unused %s", tag);
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic out_chk(input string tag, input logic [31:0] i, input logic [4:0] ipc,
                         input logic v, input logic [1:0] st);
    chk({tag, "_instr"}, ifc.instr, i);
    chk({tag, "_pc"}, {27'd0, ifc.instr_pc}, {27'd0, ipc});
    chk({tag, "_valid"}, {31'd0, ifc.instr_valid}, {31'd0, v});
    chk({tag, "_state"}, {30'd0, ifc.state}, {30'd0, st});
    chk({tag, "_halted"}, {31'd0, ifc.halted}, {31'd0, (st == 2'b10)});
  endtask

  task automatic adv_chk(input string tag, input logic exp);
    #1;
    chk({tag, "_adv"}, {31'd0, ifc.pc_advance}, {31'd0, exp});
  endtask

  task automatic prog(input logic [2:0] a, input logic [31:0] d);
    ifc.prog_we = 1'b1; ifc.prog_addr = a; ifc.prog_data = d;
    tick();
    ifc.prog_we = 1'b0;
  endtask

  initial begin
    ifc.start = 0; ifc.pc = 0; ifc.stall = 0; ifc.flush = 0;
    ifc.prog_we = 0; ifc.prog_addr = 0; ifc.prog_data = 0;
    #2;
    out_chk("reset", 32'h0, 5'd0, 1'b0, 2'b00);
    adv_chk("reset", 1'b0);
    chk_cnt("reset_cnt", 16'd0);
    #10 rst = 1'b1;

    prog(3'd0, 32'h1111_1111);
    prog(3'd1, 32'h2222_2222);
    prog(3'd2, 32'h3333_3333);
    prog(3'd3, 32'h4444_4444);
    out_chk("idle", 32'h0, 5'd0, 1'b0, 2'b00);
    adv_chk("idle", 1'b0);

    // start and a write in the same cycle: the write must still land
    ifc.start = 1;
    prog(3'd5, 32'h6666_6666);
    ifc.start = 0;
    out_chk("start", 32'h0, 5'd0, 1'b0, 2'b01);

    ifc.pc = 5'd0;  adv_chk("f0", 1'b1);
    tick(); out_chk("f0", 32'h1111_1111, 5'd0, 1'b1, 2'b01); chk_cnt("f0_cnt", 16'd1);
    ifc.pc = 5'd4;  adv_chk("f4", 1'b1);
    tick(); out_chk("f4", 32'h2222_2222, 5'd4, 1'b1, 2'b01); chk_cnt("f4_cnt", 16'd2);

    ifc.pc = 5'd8; ifc.stall = 1; adv_chk("stall", 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick(); out_chk("stall", 32'h2222_2222, 5'd4, 1'b1, 2'b01);
    end
    chk_cnt("stall_cnt", 16'd2);
    ifc.stall = 0; adv_chk("unstall", 1'b1);
    tick(); out_chk("f8", 32'h3333_3333, 5'd8, 1'b1, 2'b01); chk_cnt("f8_cnt", 16'd3);

    ifc.pc = 5'd12; ifc.flush = 1; ifc.stall = 1; adv_chk("flush", 1'b0);
    tick(); out_chk("flush", 32'h0, 5'd8, 1'b0, 2'b01); chk_cnt("flush_cnt", 16'd3);
    ifc.flush = 0; ifc.stall = 0;

    // writes in RUN are ignored
    prog(3'd0, 32'hDEAD_BEEF);
    out_chk("f12", 32'h4444_4444, 5'd12, 1'b1, 2'b01); chk_cnt("f12_cnt", 16'd4);
    ifc.pc = 5'd0;
    tick(); out_chk("f0b", 32'h1111_1111, 5'd0, 1'b1, 2'b01); chk_cnt("f0b_cnt", 16'd5);
    ifc.pc = 5'd20;
    tick(); out_chk("f20", 32'h6666_6666, 5'd20, 1'b1, 2'b01); chk_cnt("f20_cnt", 16'd6);
    ifc.pc = 5'd21;
    tick(); out_chk("f21", 32'h6666_6666, 5'd21, 1'b1, 2'b01); chk_cnt("f21_cnt", 16'd7);

    // asynchronous reset mid-cycle
    #3 rst = 1'b0;
    #1;
    out_chk("arst", 32'h0, 5'd0, 1'b0, 2'b00);
    adv_chk("arst", 1'b0);
    chk_cnt("arst_cnt", 16'd0);
    #2 rst = 1'b1;
    tick(); out_chk("post_rst", 32'h0, 5'd0, 1'b0, 2'b00);

    ifc.start = 1;
    prog(3'd3, 32'hFFFF_FFFF);
    ifc.start = 0;
    ifc.pc = 5'd4;
    tick(); out_chk("keep4", 32'h2222_2222, 5'd4, 1'b1, 2'b01); chk_cnt("keep4_cnt", 16'd1);

    // halt word fetched under flush is killed and RUN persists
    ifc.pc = 5'd12; ifc.flush = 1; adv_chk("hflush", 1'b0);
    tick(); out_chk("hflush", 32'h0, 5'd4, 1'b0, 2'b01);
    ifc.flush = 0; adv_chk("halt", 1'b0);
    tick(); out_chk("halt", 32'hFFFF_FFFF, 5'd12, 1'b1, 2'b10); chk_cnt("halt_cnt", 16'd2);
    tick(); out_chk("halt2", 32'hFFFF_FFFF, 5'd12, 1'b0, 2'b10);
    adv_chk("halt2", 1'b0);

    ifc.start = 1; ifc.flush = 1; ifc.stall = 1; ifc.pc = 5'd0;
    prog(3'd0, 32'h0);
    ifc.start = 0; ifc.flush = 0; ifc.stall = 0;
    tick(); out_chk("halt_ign", 32'hFFFF_FFFF, 5'd12, 1'b0, 2'b10); chk_cnt("halt_ign_cnt", 16'd2);

    #2 rst = 1'b0;
    #1;
    out_chk("hrst", 32'h0, 5'd0, 1'b0, 2'b00);
    rst = 1'b1;
    ifc.start = 1;
    tick();
    ifc.start = 0; ifc.pc = 5'd0;
    tick(); out_chk("final", 32'h1111_1111, 5'd0, 1'b1, 2'b01);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 The block SHALL have exactly one clock and one reset: the reset is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 rst  input  1  asynchronous active-low reset (0 = reset asserted).
REQ-004 start  input  1  leave IDLE and begin fetching.
REQ-005 pc  input  5  current byte address from the program counter.
REQ-006 stall  input  1  downstream hold request.
REQ-007 flush  input  1  taken jump or branch; kill the in-flight fetch.
REQ-008 prog_we  input  1  instruction-memory write strobe.
REQ-009 prog_addr  input  3  word index to write.
REQ-010 prog_data  input  32  word to write.
REQ-011 pc_advance  output  1  advance request to the program counter (its ctrl input).
REQ-012 instr  output  32  registered fetched instruction.
REQ-013 instr_pc  output  5  PC of the word in instr.
REQ-014 instr_valid  output  1  instr holds a live instruction.
REQ-015 state  output  2  FSM state: IDLE=00, RUN=01, HALT=10.
REQ-016 halted  output  1  high exactly when state==HALT.

Function
REQ-017 The instruction memory SHALL be 8 x 32-bit; fetch reads are indexed by pc[4:2], and pc[1:0] is ignored.
REQ-018 In IDLE, prog_we=1 SHALL write prog_data to mem[prog_addr] on the clock edge; prog_we SHALL be ignored in RUN and HALT.
REQ-019 In IDLE, start=1 SHALL move the state to RUN on the next edge; a prog_we in the same cycle SHALL still commit, and the written word SHALL be visible to the first fetch.
REQ-020 In RUN with flush=0 and stall=0, the edge SHALL load instr<=mem[pc[4:2]], instr_pc<=pc and instr_valid<=1 (latency: 1 cycle from pc to instr).
REQ-021 In RUN with flush=0 and stall=1, instr, instr_pc and instr_valid SHALL hold.
REQ-022 In RUN with flush=1, the edge SHALL set instr<=32'h0000_0000 (NOP) and instr_valid<=0; flush SHALL override stall.
REQ-023 pc_advance SHALL be combinational and equal to (state==RUN) & ~stall & ~flush & (mem[pc[4:2]] != 32'hFFFF_FFFF).
REQ-024 When a RUN fetch under REQ-020 reads 32'hFFFF_FFFF (HALT word), the word SHALL be loaded with instr_valid=1, and the state SHALL move to HALT on the same edge.
REQ-025 In HALT, instr_valid SHALL clear on the first edge; instr and instr_pc SHALL hold; start, flush, stall and prog_we SHALL be ignored; only reset SHALL exit HALT.
REQ-026 A halt fetch that coincides with flush=1 SHALL be killed per REQ-022, and the state SHALL remain RUN.
REQ-027 In IDLE, instr_valid SHALL stay 0 and pc_advance SHALL stay 0.

Reset
REQ-028 While rst=0, the block SHALL set state=IDLE, instr=0, instr_pc=0, instr_valid=0 and fetch_count=0 (when present), with halted and pc_advance following per REQ-016 and REQ-023.
REQ-029 Reset SHALL take effect immediately, including mid-RUN and in HALT; memory contents SHALL NOT be affected by reset.
REQ-030 The first edge after rst returns to 1 SHALL follow the IDLE rules.

Configuration
REQ-031 When macro IFETCH_FETCH_COUNT_EN is defined, the block SHALL add output fetch_count (16 bits), which increments on every edge performing a REQ-020 load, saturates at 16'hFFFF and resets to 0.
REQ-032 When IFETCH_FETCH_COUNT_EN is undefined, port fetch_count SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-033 Load mem[0]=32'h1111_1111 and mem[1]=32'h2222_2222 in IDLE, start, drive pc=0 then 4 -> instr=32'h1111_1111 with instr_pc=0, then instr=32'h2222_2222 with instr_pc=4, with instr_valid=1 and pc_advance=1 each cycle.
REQ-034 In RUN, hold stall=1 for 3 cycles at pc=8 -> instr, instr_pc and instr_valid frozen, pc_advance=0; release -> mem[2] is loaded on the next edge.
REQ-035 Assert flush=1 and stall=1 together at pc=12 -> the next edge gives instr=0 and instr_valid=0 with pc_advance=0; fetch_count is unchanged.
REQ-036 Place 32'hFFFF_FFFF at mem[3] and fetch pc=12 -> pc_advance=0 that cycle, instr=32'hFFFF_FFFF with instr_valid=1, then state=10, halted=1 and instr_valid=0 the next edge; later start and prog_we pulses have no effect.
REQ-037 Pull rst=0 asynchronously mid-RUN -> state=00, instr_valid=0, instr=0 and fetch_count=0 immediately, without a clock edge; after release plus start, previously loaded memory words are fetched unchanged.
REQ-038 With IFETCH_FETCH_COUNT_EN defined, perform 5 unstalled fetches with 1 flush in between -> fetch_count=5.
